tea_stream_arbiter: RTL and testbench

TEA_STREAM_ARBITER -- requirements
Module: tea_stream_arbiter

---
 rtl/tea_stream_arbiter.sv | 86 ++++++++
 tb/tb_tea_stream_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tea_stream_arbiter.sv
// tea_stream_arbiter: two-requester Avalon-ST packet arbiter with return-tag delay line.
// Statistics counters are built only when TEA_ARB_STATS_EN is defined.
module tea_stream_arbiter #(
    parameter int LATENCY = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arb_en,
    input  logic [31:0] s0_data,
    input  logic        s0_valid,
    input  logic        s0_sop,
    input  logic        s0_eop,
    input  logic [31:0] s1_data,
    input  logic        s1_valid,
    input  logic        s1_sop,
    input  logic        s1_eop,
    output logic        s0_ready,
    output logic        s1_ready,
    output logic [31:0] m_data,
    output logic        m_valid,
    output logic        m_sop,
    output logic        m_eop,
    input  logic        m_ready,
    output logic        m_chan,
    output logic        ret_chan,
    output logic [15:0] pkt_cnt0,
    output logic [15:0] pkt_cnt1,
    output logic [15:0] drop_cnt
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
    state_t state;
    logic last_grant, idle, req0, req1, orph0, orph1, xfer, done;
    logic [LATENCY-1:0] tag_line;
    assign idle = state == IDLE;
    assign m_chan = state == GRANT1;
    assign req0 = s0_valid & s0_sop;
    assign req1 = s1_valid & s1_sop;
    // orphans are gated by rst_n so ready stays low while reset is held
    assign orph0 = rst_n & idle & s0_valid & ~s0_sop;
    assign orph1 = rst_n & idle & s1_valid & ~s1_sop;
    assign m_valid = ~idle & (m_chan ? s1_valid : s0_valid);
    assign m_sop = ~idle & (m_chan ? s1_sop : s0_sop);
    assign m_eop = ~idle & (m_chan ? s1_eop : s0_eop);
    assign m_data = idle ? '0 : (m_chan ? s1_data : s0_data);
    assign s0_ready = (state == GRANT0 & m_ready) | orph0;
    assign s1_ready = (m_chan & m_ready) | orph1;
    assign xfer = m_valid & m_ready;
    assign done = xfer & m_eop;
    assign ret_chan = tag_line[LATENCY-1];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last_grant <= 1'b1;
            tag_line <= '0;
        end else begin
            case (state)
                IDLE: if (arb_en && (req0 || req1)) state <= (req0 && (!req1 || last_grant)) ? GRANT0 : GRANT1;
                default: if (done) begin
                    state <= IDLE;
                    last_grant <= m_chan;
                end
            endcase
            if (xfer) begin
                for (int i = LATENCY - 1; i > 0; i--) tag_line[i] <= tag_line[i-1];
                tag_line[0] <= m_chan;
            end
        end
    end
`ifdef TEA_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
            drop_cnt <= '0;
        end else begin
            if (done && !m_chan) pkt_cnt0 <= pkt_cnt0 + 16'd1;
            if (done && m_chan) pkt_cnt1 <= pkt_cnt1 + 16'd1;
            drop_cnt <= drop_cnt + 16'(orph0) + 16'(orph1);
        end
    end
`else
    assign pkt_cnt0 = '0;
    assign pkt_cnt1 = '0;
    assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_tea_stream_arbiter.sv
// tb_tea_stream_arbiter: table vectors plus scoreboarded packet sequences for tea_stream_arbiter.
module tb_tea_stream_arbiter;
    localparam int LAT = 16;
    localparam bit STATS = `ifdef TEA_ARB_STATS_EN 1'b1 `else 1'b0 `endif;
    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        e;
    } beat_t;
    typedef struct {
        bit       en;
        bit [1:0] v;
        bit [1:0] p;
        bit [1:0] r;
        int       g;
    } vec_t;
    logic clk = 0, rst_n = 0, arb_en = 1, m_ready = 1;
    logic [1:0] sv = 0, ss = 0, se = 0, sr;
    logic [31:0] sd[2];
    logic [31:0] m_data;
    logic m_valid, m_sop, m_eop, m_chan, ret_chan;
    logic [15:0] pkt_cnt0, pkt_cnt1, drop_cnt;
    int checks = 0, errors = 0, exp_pkt0 = 0, exp_pkt1 = 0, exp_drop = 0;
    beat_t q0[$], q1[$];
    bit hist[$];
    bit hold = 0;
    logic [31:0] prev_d;
    vec_t tbl[10];
    bit [7:0] vpat, cpat;
    time t0;

    tea_stream_arbiter #(.LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
        .s0_data(sd[0]), .s0_valid(sv[0]), .s0_sop(ss[0]), .s0_eop(se[0]),
        .s1_data(sd[1]), .s1_valid(sv[1]), .s1_sop(ss[1]), .s1_eop(se[1]),
        .s0_ready(sr[0]), .s1_ready(sr[1]),
        .m_data(m_data), .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop), .m_ready(m_ready),
        .m_chan(m_chan), .ret_chan(ret_chan),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_cnt(input string tag);
        chk({tag, " pkt_cnt0"}, 32'(pkt_cnt0), STATS ? 32'(exp_pkt0) : 32'd0);
        chk({tag, " pkt_cnt1"}, 32'(pkt_cnt1), STATS ? 32'(exp_pkt1) : 32'd0);
        chk({tag, " drop_cnt"}, 32'(drop_cnt), STATS ? 32'(exp_drop) : 32'd0);
    endtask

    task automatic clear_model();
        q0.delete();
        q1.delete();
        hist.delete();
        exp_pkt0 = 0;
        exp_pkt1 = 0;
        exp_drop = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 0;
        clear_model();
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic send(input int ch, input int n, input logic [31:0] base, input bit sop0, input int npush);
        for (int i = 0; i < n; i++) begin
            int w;
            beat_t b;
            w = 0;
            sd[ch] = base + 32'(i);
            sv[ch] = 1'b1;
            ss[ch] = (i == 0) && sop0;
            se[ch] = (i == n - 1);
            if (i < npush) begin
                b.d = sd[ch];
                b.s = ss[ch];
                b.e = se[ch];
                if (ch == 1) begin
                    q1.push_back(b);
                    if (b.e) exp_pkt1++;
                end else begin
                    q0.push_back(b);
                    if (b.e) exp_pkt0++;
                end
            end
            do begin
                @(negedge clk);
                w++;
            end while (!sr[ch] && w < 200);
            if (!sr[ch]) begin
                checks++;
                errors++;
                $display("FAIL send ch%0d beat %0d: no ready within 200 cycles", ch, i);
                sv[ch] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        sv[ch] = 1'b0;
        ss[ch] = 1'b0;
        se[ch] = 1'b0;
    endtask

    // scoreboard: every transfer must match the oldest expected beat of its channel
    always @(negedge clk) begin
        if (!rst_n) hold = 0;
        else begin
            if (hold) chk("data held under backpressure", m_data, prev_d);
            hold = m_valid && !m_ready;
            prev_d = m_data;
            if (m_valid && m_ready) begin
                int hs;
                beat_t e;
                hs = hist.size();
                chk("ret_chan", 32'(ret_chan), 32'(hs >= LAT ? hist[hs-LAT] : 1'b0));
                if ((m_chan && q1.size() == 0) || (!m_chan && q0.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected beat: chan %0d data %h, none expected", m_chan, m_data);
                end else begin
                    e = m_chan ? q1.pop_front() : q0.pop_front();
                    chk("m_data", m_data, e.d);
                    chk("m_sop", 32'(m_sop), 32'(e.s));
                    chk("m_eop", 32'(m_eop), 32'(e.e));
                end
                hist.push_back(m_chan);
            end
        end
    end

    initial begin
        tbl[0] = '{1, 2'b11, 2'b11, 2'b00, 1};
        tbl[1] = '{1, 2'b11, 2'b11, 2'b00, 2};
        tbl[2] = '{1, 2'b01, 2'b01, 2'b00, 1};
        tbl[3] = '{1, 2'b10, 2'b10, 2'b00, 2};
        tbl[4] = '{0, 2'b11, 2'b11, 2'b00, 0};
        tbl[5] = '{1, 2'b11, 2'b10, 2'b01, 2};
        tbl[6] = '{0, 2'b11, 2'b00, 2'b11, 0};
        tbl[7] = '{1, 2'b00, 2'b00, 2'b00, 0};
        tbl[8] = '{1, 2'b11, 2'b01, 2'b10, 1};
        tbl[9] = '{1, 2'b11, 2'b11, 2'b00, 2};
        sd[0] = 32'h1234_5678;
        sd[1] = 32'h0;
        sv = 2'b01;
        ss = 2'b01;
        se = 2'b01;
        @(negedge clk);
        chk("reset m_valid", 32'(m_valid), 0);
        chk("reset m_sop", 32'(m_sop), 0);
        chk("reset m_eop", 32'(m_eop), 0);
        chk("reset m_data", m_data, 0);
        chk("reset ready", 32'(sr), 0);
        chk("reset m_chan", 32'(m_chan), 0);
        chk("reset ret_chan", 32'(ret_chan), 0);
        check_cnt("reset");
        sv = 0;
        ss = 0;
        se = 0;
        @(posedge clk);
        #1 rst_n = 1;

        for (int k = 0; k < 10; k++) begin
            beat_t b;
            @(posedge clk);
            #1;
            arb_en = tbl[k].en;
            sv = tbl[k].v;
            ss = tbl[k].p;
            se = 2'b11;
            m_ready = 1;
            sd[0] = 32'h0A00_0000 + 32'(k);
            sd[1] = 32'h8B00_0000 + 32'(k);
            exp_drop += $countones(tbl[k].v & ~tbl[k].p);
            b.s = 1;
            b.e = 1;
            if (tbl[k].g == 1) begin
                b.d = sd[0];
                q0.push_back(b);
                exp_pkt0++;
            end else if (tbl[k].g == 2) begin
                b.d = sd[1];
                q1.push_back(b);
                exp_pkt1++;
            end
            @(negedge clk);
            chk($sformatf("row%0d idle ready", k), 32'(sr), 32'(tbl[k].r));
            chk($sformatf("row%0d idle m_valid", k), 32'(m_valid), 0);
            @(posedge clk);
            #1 sv = sv & ss;
            @(negedge clk);
            chk($sformatf("row%0d grant m_valid", k), 32'(m_valid), 32'(tbl[k].g != 0));
            if (tbl[k].g != 0) chk($sformatf("row%0d m_chan", k), 32'(m_chan), 32'(tbl[k].g - 1));
            @(posedge clk);
            #1;
            sv = 0;
            ss = 0;
            arb_en = 1;
        end
        check_cnt("table");

        do_reset();
        vpat = 8'b1110_1110;
        cpat = 8'b1110_0000;
        fork
            send(0, 3, 32'h1100_0000, 1, 3);
            send(1, 3, 32'h9100_0000, 1, 3);
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                chk($sformatf("tie cycle%0d m_valid", i + 1), 32'(m_valid), 32'(vpat[i]));
                if (vpat[i]) chk($sformatf("tie cycle%0d m_chan", i + 1), 32'(m_chan), 32'(cpat[i]));
            end
        join
        check_cnt("tie");

        do_reset();
        t0 = $time;
        for (int p = 0; p < 4; p++) send(1, 2, 32'h9200_0000 + 32'(p * 16), 1, 2);
        chk("back-to-back cycles", 32'(($time - t0) / 10), 12);
        check_cnt("back-to-back");

        do_reset();
        fork
            send(0, 4, 32'h1300_0000, 1, 4);
            for (int i = 0; i < 12; i++) begin
                m_ready = (i % 2 == 0);
                @(negedge clk);
                chk("backpressure s1_ready", 32'(sr[1]), 0);
                @(posedge clk);
                #1;
            end
        join
        m_ready = 1;
        check_cnt("backpressure");

        do_reset();
        fork
            send(0, 1, 32'hDEAD_BEEF, 0, 0);
            begin
                @(negedge clk);
                chk("orphan m_valid", 32'(m_valid), 0);
                chk("orphan s0_ready", 32'(sr[0]), 1);
            end
        join
        exp_drop = 1;
        repeat (2) @(posedge clk);
        check_cnt("orphan");

        do_reset();
        send(0, 16, 32'h1400_0000, 1, 16);
        chk("ret_chan after 16", 32'(ret_chan), 0);
        send(1, 16, 32'h9400_0000, 1, 16);
        chk("ret_chan after 32", 32'(ret_chan), 1);

        do_reset();
        fork
            send(0, 4, 32'h1500_0000, 1, 4);
            begin
                repeat (2) @(posedge clk);
                #1 arb_en = 0;
            end
        join
        fork
            send(1, 2, 32'h9500_0000, 1, 2);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("arb_en=0 m_valid", 32'(m_valid), 0);
                    chk("arb_en=0 s1_ready", 32'(sr[1]), 0);
                end
                @(posedge clk);
                #1 arb_en = 1;
            end
        join
        check_cnt("arb_en");
        fork
            send(0, 5, 32'h1600_0000, 1, 2);
            begin
                repeat (3) @(posedge clk);
                #2 rst_n = 0;
                clear_model();
                @(negedge clk);
                chk("midreset m_valid", 32'(m_valid), 0);
                chk("midreset m_sop", 32'(m_sop), 0);
                chk("midreset m_eop", 32'(m_eop), 0);
                chk("midreset m_data", m_data, 0);
                chk("midreset ready", 32'(sr), 0);
                chk("midreset m_chan", 32'(m_chan), 0);
                chk("midreset ret_chan", 32'(ret_chan), 0);
                @(posedge clk);
                #1 rst_n = 1;
            end
        join
        exp_drop = 3;
        repeat (2) @(posedge clk);
        check_cnt("midreset");

        repeat (2) @(posedge clk);
        chk("ch0 beats outstanding", 32'(q0.size()), 0);
        chk("ch1 beats outstanding", 32'(q1.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
